// File: rtl/id_exe_pkg.sv
// Shared widths, payload layout and ALU opcode encodings for the ID->EXE stage.
// Payload order (MSB first): rdata1, rdata2, imm, opcode, alusrc, memwrite,
// memtoreg, writeenable, waddr, branch, unconditional_branch, PC, INST.
package id_exe_pkg;

    localparam int DEF_DSIZE  = 16;
    localparam int DEF_ASIZE  = 4;
    localparam int DEF_ISIZE  = 16;
    localparam int DEF_OPSIZE = 3;

    function automatic int payload_w(input int dsize, input int asize,
                                     input int isize, input int opsize);
        // four data-wide fields, six single-bit controls
        return 4 * dsize + opsize + asize + isize + 6;
    endfunction

    localparam int PAYLOAD_W = payload_w(DEF_DSIZE, DEF_ASIZE, DEF_ISIZE, DEF_OPSIZE);

    localparam logic [DEF_OPSIZE-1:0] OP_ADD = 3'd0;
    localparam logic [DEF_OPSIZE-1:0] OP_SUB = 3'd1;
    localparam logic [DEF_OPSIZE-1:0] OP_AND = 3'd2;
    localparam logic [DEF_OPSIZE-1:0] OP_OR  = 3'd3;
    localparam logic [DEF_OPSIZE-1:0] OP_XOR = 3'd4;
    localparam logic [DEF_OPSIZE-1:0] OP_SLT = 3'd5;
    localparam logic [DEF_OPSIZE-1:0] OP_SLL = 3'd6;
    localparam logic [DEF_OPSIZE-1:0] OP_SRL = 3'd7;

endpackage

// File: rtl/elastic_slot.sv
// One buffer entry: payload register plus valid bit. Priority rst > clear > load;
// reset also zeroes the payload so downstream fields read 0 after reset.
module elastic_slot
    import id_exe_pkg::*;
#(
    parameter int W = PAYLOAD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/id_exe_elastic_stage.sv
// Elastic ID->EXE register: main entry feeds EXE, skid entry absorbs the one
// instruction accepted while EXE stalls, so in_ready depends only on registered state.
module id_exe_elastic_stage
    import id_exe_pkg::*;
#(
    parameter int DSIZE  = DEF_DSIZE,
    parameter int ASIZE  = DEF_ASIZE,
    parameter int ISIZE  = DEF_ISIZE,
    parameter int OPSIZE = DEF_OPSIZE,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [DSIZE-1:0]  rdata1_in,
    output logic [DSIZE-1:0]  rdata1_out,
    input  logic [DSIZE-1:0]  rdata2_in,
    output logic [DSIZE-1:0]  rdata2_out,
    input  logic [DSIZE-1:0]  imm_in,
    output logic [DSIZE-1:0]  imm_out,
    input  logic [OPSIZE-1:0] opcode_in,
    output logic [OPSIZE-1:0] opcode_out,
    input  logic              alusrc_in,
    output logic              alusrc_out,
    input  logic              memwrite_in,
    output logic              memwrite_out,
    input  logic              memtoreg_in,
    output logic              memtoreg_out,
    input  logic              writeenable_in,
    output logic              writeenable_out,
    input  logic [ASIZE-1:0]  waddr_in,
    output logic [ASIZE-1:0]  waddr_out,
    input  logic              branch_in,
    output logic              branch_out,
    input  logic              unconditional_branch_in,
    output logic              unconditional_branch_out,
    input  logic [DSIZE-1:0]  PC_in,
    output logic [DSIZE-1:0]  PC_out,
    input  logic [ISIZE-1:0]  INST_in,
    output logic [ISIZE-1:0]  INST_out,
    output logic [CNTW-1:0]   stall_cnt
);

    localparam int PW = payload_w(DSIZE, ASIZE, ISIZE, OPSIZE);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [PW-1:0] pack_in, main_d, main_q, skid_q;
    logic          main_valid, skid_valid;
    logic          accept, fire;
    logic          main_load, main_clear, skid_load, skid_clear;
    logic          memwrite_raw, writeenable_raw, branch_raw, ubranch_raw;

    assign pack_in = {rdata1_in, rdata2_in, imm_in, opcode_in, alusrc_in, memwrite_in,
                      memtoreg_in, writeenable_in, waddr_in, branch_in,
                      unconditional_branch_in, PC_in, INST_in};

    assign in_ready  = !skid_valid && !rst;
    assign out_valid = main_valid;
    assign accept    = in_valid && in_ready;
    assign fire      = main_valid && out_ready;

    // Skid is always older than the incoming word, so it has first claim on main.
    assign main_d     = skid_valid ? skid_q : pack_in;
    assign main_load  = (fire && skid_valid) || (accept && (!main_valid || fire));
    assign main_clear = flush || (fire && !skid_valid && !accept);
    assign skid_load  = accept && main_valid && !fire;
    assign skid_clear = flush || (fire && skid_valid);

    elastic_slot #(.W(PW)) u_main (
        .clk   (clk),
        .rst   (rst),
        .clear (main_clear),
        .load  (main_load),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    elastic_slot #(.W(PW)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clear (skid_clear),
        .load  (skid_load),
        .d     (pack_in),
        .valid (skid_valid),
        .q     (skid_q)
    );

    assign {rdata1_out, rdata2_out, imm_out, opcode_out, alusrc_out, memwrite_raw,
            memtoreg_out, writeenable_raw, waddr_out, branch_raw, ubranch_raw,
            PC_out, INST_out} = main_q;

    // Side-effecting controls must not leak out of a bubble.
    assign memwrite_out             = memwrite_raw    && main_valid;
    assign writeenable_out          = writeenable_raw && main_valid;
    assign branch_out               = branch_raw      && main_valid;
    assign unconditional_branch_out = ubranch_raw     && main_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_exe_elastic_stage.sv
// Bench for id_exe_elastic_stage: directed table, hand-written corner sequences,
// then randomized traffic checked against a 2-deep FIFO reference model.
module tb_id_exe_elastic_stage;
    import id_exe_pkg::*;

    localparam int CNTW = 4;
    localparam int CMAX = 15;

    typedef struct packed {
        logic [15:0] rdata1;
        logic [15:0] rdata2;
        logic [15:0] imm;
        logic [2:0]  opcode;
        logic        alusrc;
        logic        memwrite;
        logic        memtoreg;
        logic        writeenable;
        logic [3:0]  waddr;
        logic        branch;
        logic        ubranch;
        logic [15:0] pc;
        logic [15:0] inst;
    } pl_t;

    typedef struct {
        bit          rst;
        bit          flush;
        bit          iv;
        bit          ordy;
        logic [15:0] pc;
        bit          ov;
        bit          ir;
        logic [15:0] opc;
        int          cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst, flush, in_valid, out_ready, in_ready, out_valid;
    logic [CNTW-1:0] stall_cnt;
    pl_t din;
    pl_t dout;

    logic [15:0] o_rdata1, o_rdata2, o_imm, o_pc, o_inst;
    logic [2:0]  o_opcode;
    logic [3:0]  o_waddr;
    logic        o_alusrc, o_memwrite, o_memtoreg, o_we, o_branch, o_ubranch;

    always #5 clk = ~clk;

    id_exe_elastic_stage #(.CNTW(CNTW)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .in_valid                 (in_valid),
        .in_ready                 (in_ready),
        .flush                    (flush),
        .out_valid                (out_valid),
        .out_ready                (out_ready),
        .rdata1_in                (din.rdata1),
        .rdata1_out               (o_rdata1),
        .rdata2_in                (din.rdata2),
        .rdata2_out               (o_rdata2),
        .imm_in                   (din.imm),
        .imm_out                  (o_imm),
        .opcode_in                (din.opcode),
        .opcode_out               (o_opcode),
        .alusrc_in                (din.alusrc),
        .alusrc_out               (o_alusrc),
        .memwrite_in              (din.memwrite),
        .memwrite_out             (o_memwrite),
        .memtoreg_in              (din.memtoreg),
        .memtoreg_out             (o_memtoreg),
        .writeenable_in           (din.writeenable),
        .writeenable_out          (o_we),
        .waddr_in                 (din.waddr),
        .waddr_out                (o_waddr),
        .branch_in                (din.branch),
        .branch_out               (o_branch),
        .unconditional_branch_in  (din.ubranch),
        .unconditional_branch_out (o_ubranch),
        .PC_in                    (din.pc),
        .PC_out                   (o_pc),
        .INST_in                  (din.inst),
        .INST_out                 (o_inst),
        .stall_cnt                (stall_cnt)
    );

    assign dout = {o_rdata1, o_rdata2, o_imm, o_opcode, o_alusrc, o_memwrite, o_memtoreg,
                   o_we, o_waddr, o_branch, o_ubranch, o_pc, o_inst};

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: the stage behaves as a 2-deep FIFO whose readiness is decided
    // by the occupancy at the start of the cycle.
    pl_t q[$];
    int  m_cnt = 0;
    bit  m_was_rst = 0;

    task automatic model_step();
        bit m_ir, m_ov;
        m_ir = (q.size() < 2) && !rst;
        m_ov = q.size() > 0;
        m_was_rst = rst;
        if (rst) begin
            q.delete();
            m_cnt = 0;
        end else begin
            if (m_ov && !out_ready && m_cnt < CMAX) m_cnt++;
            if (flush) begin
                q.delete();
            end else begin
                if (m_ov && out_ready) void'(q.pop_front());
                if (in_valid && m_ir) q.push_back(din);
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, (q.size() < 2) && !rst);
        chk("stall_cnt", stall_cnt, m_cnt);
        if (q.size() > 0)
            chk("payload", dout, q[0]);
        else if (m_was_rst)
            chk("reset_payload", dout, 0);
        else
            chk("bubble_gating", {o_memwrite, o_we, o_branch, o_ubranch}, 4'b0000);
    endtask

    function automatic logic [2:0] pick_op(input int k);
        case (k)
            0: return OP_ADD;
            1: return OP_SUB;
            2: return OP_AND;
            3: return OP_OR;
            4: return OP_XOR;
            5: return OP_SLT;
            6: return OP_SLL;
            default: return OP_SRL;
        endcase
    endfunction

    vec_t tbl[18];

    initial begin
        int bias;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        din = '0;
        din.rdata1 = 16'h1111; din.rdata2 = 16'h2222; din.imm = 16'hfff0;
        din.opcode = OP_ADD; din.memwrite = 1'b1; din.writeenable = 1'b1;
        din.branch = 1'b1; din.ubranch = 1'b1; din.waddr = 4'h5; din.inst = 16'hbeef;

        //          rst fl iv rdy pc        ov ir out_pc   cnt
        tbl[0]  = '{1, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 0};
        tbl[1]  = '{0, 0, 1, 1, 16'h0010, 1, 1, 16'h0010, 0};
        tbl[2]  = '{0, 0, 1, 1, 16'h0012, 1, 1, 16'h0012, 0};
        tbl[3]  = '{0, 0, 1, 1, 16'h0014, 1, 1, 16'h0014, 0};
        tbl[4]  = '{0, 0, 1, 1, 16'h0016, 1, 1, 16'h0016, 0};
        tbl[5]  = '{0, 0, 0, 1, 16'h0000, 0, 1, 16'h0000, 0};
        tbl[6]  = '{0, 0, 1, 0, 16'h0018, 1, 1, 16'h0018, 0};
        tbl[7]  = '{0, 0, 1, 0, 16'h001a, 1, 0, 16'h0018, 1};
        tbl[8]  = '{0, 0, 1, 0, 16'h001c, 1, 0, 16'h0018, 2};
        tbl[9]  = '{0, 0, 1, 0, 16'h001c, 1, 0, 16'h0018, 3};
        tbl[10] = '{0, 0, 1, 1, 16'h001c, 1, 1, 16'h001a, 3};
        tbl[11] = '{0, 0, 1, 1, 16'h001c, 1, 1, 16'h001c, 3};
        tbl[12] = '{0, 0, 0, 1, 16'h0000, 0, 1, 16'h0000, 3};
        tbl[13] = '{0, 0, 1, 0, 16'h0020, 1, 1, 16'h0020, 3};
        tbl[14] = '{0, 0, 1, 0, 16'h0022, 1, 0, 16'h0020, 4};
        tbl[15] = '{0, 1, 1, 0, 16'h0024, 0, 1, 16'h0000, 5};
        tbl[16] = '{0, 0, 1, 1, 16'h0026, 1, 1, 16'h0026, 5};
        tbl[17] = '{0, 0, 0, 1, 16'h0000, 0, 1, 16'h0000, 5};

        for (int i = 0; i < 18; i++) begin
            rst = tbl[i].rst; flush = tbl[i].flush;
            in_valid = tbl[i].iv; out_ready = tbl[i].ordy; din.pc = tbl[i].pc;
            cycle();
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].ir);
            chk($sformatf("tbl%0d_stall_cnt", i), stall_cnt, tbl[i].cnt);
            if (tbl[i].ov)
                chk($sformatf("tbl%0d_pc_out", i), o_pc, tbl[i].opc);
            else
                chk($sformatf("tbl%0d_gating", i), {o_memwrite, o_we, o_branch, o_ubranch}, 4'b0000);
        end

        // Saturation: one held instruction, EXE stalled for 20 cycles.
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cycle();
        rst = 1'b0; in_valid = 1'b1; din.pc = 16'h0030;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        chk("sat_stall_cnt", stall_cnt, 4'd15);
        chk("sat_pc_stable", o_pc, 16'h0030);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("sat_after_flush_cnt", stall_cnt, 4'd15);
        chk("sat_after_flush_valid", out_valid, 1'b0);
        rst = 1'b1;
        cycle();
        chk("sat_after_rst_cnt", stall_cnt, 4'd0);

        // Reset while FULL discards both entries.
        rst = 1'b0; in_valid = 1'b1; out_ready = 1'b0; din.pc = 16'h0040;
        cycle();
        din.pc = 16'h0042;
        cycle();
        chk("full_in_ready", in_ready, 1'b0);
        rst = 1'b1;
        cycle();
        chk("rst_full_valid", out_valid, 1'b0);
        chk("rst_full_ready", in_ready, 1'b0);
        chk("rst_full_payload", dout, 0);
        chk("rst_full_cnt", stall_cnt, 4'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_release_ready", in_ready, 1'b1);

        // Randomized traffic against the FIFO model.
        rst = 1'b1;
        cycle();
        check_model();
        bias = 60;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0: bias = 20;
                    1: bias = 60;
                    default: bias = 95;
                endcase
            end
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 99) < bias);
            din.rdata1      = 16'($urandom);
            din.rdata2      = 16'($urandom);
            din.imm         = 16'($urandom);
            din.opcode      = pick_op($urandom_range(0, 7));
            din.alusrc      = 1'($urandom);
            din.memwrite    = 1'($urandom);
            din.memtoreg    = 1'($urandom);
            din.writeenable = 1'($urandom);
            din.waddr       = 4'($urandom);
            din.branch      = 1'($urandom);
            din.ubranch     = 1'($urandom);
            din.pc          = 16'($urandom);
            din.inst        = 16'($urandom);
            cycle();
            check_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
